wrra: RTL and testbench

Weighted round-robin arbiter: grants one of `WIDTH` requesters at a time and holds the grant for up to a per-requester quantum of cycles. The next owner is chosen in rotating priority order, starting after the current owner. It is the weighted, burst-holding successor of the parallel round-robin arbiter and sits in front of shared buses and memory ports where requesters need multi-cycle ownership.

---
 rtl/wrra.sv | 95 +++++++++
 tb/tb_wrra.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wrra.sv
// Weighted round-robin arbiter: one owner at a time, held for up to its weight in cycles,
// with the next owner searched in rotating order starting after the current or most recent owner.
module wrra #(
    parameter int WIDTH        = 4,
    parameter int LOG2_WIDTH   = $clog2(WIDTH),
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [WIDTH-1:0]              request,
    input  logic [WIDTH*WEIGHT_WIDTH-1:0] weight,
    output logic [WIDTH-1:0]              grant,
    output logic                          grant_valid,
    output logic                          grant_last,
    output logic [LOG2_WIDTH-1:0]         state,
    output logic [WEIGHT_WIDTH-1:0]       credit
);

    logic [WEIGHT_WIDTH-1:0] eff_weight [WIDTH];

    logic [WIDTH-1:0]        grant_q, grant_d;
    logic [LOG2_WIDTH-1:0]   state_q, state_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic                    valid_q, last_q;

    logic [LOG2_WIDTH-1:0]   winner;
    logic [LOG2_WIDTH-1:0]   cand;
    logic                    found;
    logic                    rearb;

    // A zero weight still buys one cycle of ownership.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_weight
            assign eff_weight[gi] = (weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                                  ? WEIGHT_WIDTH'(1)
                                  : weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    endgenerate

    // Scan from farthest to nearest so the nearest hit after state_q wins.
    always_comb begin
        found  = 1'b0;
        winner = state_q;
        cand   = '0;
        for (int k = WIDTH; k >= 1; k--) begin
            cand = LOG2_WIDTH'((int'(state_q) + k) % WIDTH);
            if (request[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign rearb = !(|grant_q) || !request[state_q] || (credit_q == WEIGHT_WIDTH'(1));

    always_comb begin
        grant_d  = grant_q;
        state_d  = state_q;
        credit_d = credit_q;
        if (rearb) begin
            grant_d  = '0;
            credit_d = '0;
            if (found) begin
                grant_d[winner] = 1'b1;
                state_d         = winner;
                credit_d        = eff_weight[winner];
            end
        end else begin
            credit_d = credit_q - WEIGHT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            grant_q  <= '0;
            state_q  <= LOG2_WIDTH'(WIDTH - 1);
            credit_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            state_q  <= state_d;
            credit_q <= credit_d;
            valid_q  <= |grant_d;
            last_q   <= (credit_d == WEIGHT_WIDTH'(1));
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_last  = last_q;
    assign state       = state_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_wrra.sv
// Self-checking bench for wrra: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural arbitration model.
module tb_wrra;

    localparam int N  = 4;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          arst_n = 1'b1;
    logic [N-1:0]  request = '0;
    logic [N*WW-1:0] weight = '0;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic          grant_last;
    logic [1:0]    state;
    logic [WW-1:0] credit;

    int n_cmp = 0;
    int n_bad = 0;

    wrra #(.WIDTH(N), .LOG2_WIDTH(2), .WEIGHT_WIDTH(WW)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .request    (request),
        .weight     (weight),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_last (grant_last),
        .state      (state),
        .credit     (credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = idle), last owner, remaining cycles.
    int m_owner  = -1;
    int m_last   = N - 1;
    int m_credit = 0;

    function automatic int weff(input int i);
        int w;
        w = int'(weight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    always @(negedge arst_n) begin
        m_owner  = -1;
        m_last   = N - 1;
        m_credit = 0;
    end

    always @(posedge clk) begin
        if (arst_n) begin
            if (m_owner < 0 || !request[m_owner] || m_credit == 1) begin
                int w;
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && request[(m_last + k) % N]) w = (m_last + k) % N;
                end
                if (w >= 0) begin
                    m_owner  = w;
                    m_last   = w;
                    m_credit = weff(w);
                end else begin
                    m_owner  = -1;
                    m_credit = 0;
                end
            end else begin
                m_credit = m_credit - 1;
            end
        end
    end

    // Single compare process: outputs are checked every cycle on the falling edge.
    always @(negedge clk) begin
        int exp_g;
        exp_g = (m_owner < 0) ? 0 : (1 << m_owner);
        chk("model_grant",  int'(grant),       exp_g);
        chk("model_valid",  int'(grant_valid), (m_owner >= 0) ? 1 : 0);
        chk("model_last",   int'(grant_last),  (m_credit == 1) ? 1 : 0);
        chk("model_state",  int'(state),       m_last);
        chk("model_credit", int'(credit),      m_credit);
    end

    int rot_g [10] = '{1, 2, 2, 4, 4, 4, 8, 8, 8, 8};
    int rot_l [10] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    int er_g  [8]  = '{1, 1, 2, 2, 2, 2, 2, 2};
    int er_c  [8]  = '{4, 3, 4, 3, 2, 1, 4, 3};

    initial begin
        bit hit;
        weight = {4'd4, 4'd4, 4'd4, 4'd4};
        #1 arst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_state", int'(state), 3);
        chk("rst_credit", int'(credit), 0);
        $display("reset: grant=%b state=%0d credit=%0d", grant, state, credit);

        // Weighted rotation
        arst_n  = 1'b1;
        request = 4'b1111;
        weight  = {4'd4, 4'd3, 4'd2, 4'd1};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rot_grant", int'(grant), rot_g[i % 10]);
            chk("rot_last", int'(grant_last), rot_l[i % 10]);
            $display("rotation cycle %0d: grant=%b last=%b", i, grant, grant_last);
        end

        // Reset mid-quantum at credit 2
        weight = {4'd4, 4'd4, 4'd4, 4'd4};
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (credit == 4'd2) hit = 1'b1;
        end
        chk("wait_credit2", int'(hit), 1);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_grant", int'(grant), 0);
        chk("arst_state", int'(state), 3);
        chk("arst_credit", int'(credit), 0);
        chk("arst_last", int'(grant_last), 0);
        $display("async reset: grant=%b state=%0d credit=%0d last=%b", grant, state, credit, grant_last);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", int'(grant), 1);
        $display("after release: grant=%b", grant);

        // Zero weight, single requester
        request = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        weight  = {4'd4, 4'd0, 4'd4, 4'd4};
        request = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("zw_grant", int'(grant), 4);
            chk("zw_credit", int'(credit), 1);
            chk("zw_last", int'(grant_last), 1);
            $display("zero weight cycle %0d: grant=%b credit=%0d", i, grant, credit);
        end

        // Early release
        request = 4'b0000;
        @(negedge clk);
        weight  = {4'd4, 4'd4, 4'd4, 4'd4};
        request = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("er_grant", int'(grant), er_g[i]);
            chk("er_credit", int'(credit), er_c[i]);
            $display("early release cycle %0d: grant=%b credit=%0d", i, grant, credit);
            if (i == 1) request = 4'b0010;
        end

        // Weight change mid-quantum
        request = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        weight  = {4'd4, 4'd4, 4'd3, 4'd4};
        request = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wc_grant", int'(grant), 2);
            chk("wc_credit", int'(credit), (i < 3) ? 3 - i : 1);
            $display("weight change cycle %0d: grant=%b credit=%0d", i, grant, credit);
            if (i == 0) weight = {4'd4, 4'd4, 4'd1, 4'd4};
        end

        // Idle resume
        request = 4'b0000;
        weight  = {4'd4, 4'd4, 4'd4, 4'd4};
        @(negedge clk);
        request = 4'b0100;
        @(negedge clk);
        chk("ir_own2", int'(grant), 4);
        request = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ir_idle_grant", int'(grant), 0);
            chk("ir_idle_state", int'(state), 2);
        end
        request = 4'b0101;
        @(negedge clk);
        chk("ir_resume", int'(grant), 1);
        $display("idle resume: grant=%b state=%0d", grant, state);

        // Randomized phase against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) < 3) request = N'($urandom);
            if ($urandom_range(0, 19) == 0) weight[$urandom_range(0, N-1)*WW +: WW] = WW'($urandom_range(0, 5));
            if ($urandom_range(0, 149) == 0) begin
                #2 arst_n = 1'b0;
                #1 chk("rand_arst_grant", int'(grant), 0);
                @(negedge clk);
                arst_n = 1'b1;
            end
            $display("random cycle %0d: req=%b grant=%b credit=%0d state=%0d", i, request, grant, credit, state);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
